// File: rtl/vmem_fill_ctrl.sv
// Rectangle fill engine for video memory with CPU write priority and a small cfg register file.
// Optional fill-complete interrupt enabled by defining VFILL_IRQ_EN.
module vmem_fill_ctrl #(
  parameter int unsigned XMAX = 239,
  parameter int unsigned YMAX = 239
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [15:0] vmem_wdata_o,
  output logic        busy_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  localparam logic [8:0] XLIM = 9'(XMAX);
  localparam logic [8:0] YLIM = 9'(YMAX);

  state_t      state_q, state_nxt;
  logic [31:0] rect_q;
  logic [15:0] color_q;
  logic [7:0]  x_q, y_q;
  logic        done_q, err_q;
  logic        irq_en_rd;
  logic [31:0] rdata_nxt;

  logic [7:0] x0, y0, x1, y1;
  assign x0 = rect_q[7:0];
  assign y0 = rect_q[15:8];
  assign x1 = rect_q[23:16];
  assign y1 = rect_q[31:24];

  logic rect_wr, color_wr, ctrl_wr, status_wr;
  logic start_req, abort_req, rect_ok, start_go, start_bad;
  logic fill_wr, fill_step, last_px;

  assign rect_wr   = cfg_we_i && (cfg_addr_i == 2'd0) && (state_q == ST_IDLE);
  assign color_wr  = cfg_we_i && (cfg_addr_i == 2'd1) && (state_q == ST_IDLE);
  assign ctrl_wr   = cfg_we_i && (cfg_addr_i == 2'd2);
  assign status_wr = cfg_we_i && (cfg_addr_i == 2'd3);
  assign start_req = ctrl_wr && cfg_wdata_i[0];
  assign abort_req = ctrl_wr && cfg_wdata_i[1];

  assign rect_ok   = (x0 <= x1) && (y0 <= y1) &&
                     ({1'b0, x1} <= XLIM) && ({1'b0, y1} <= YLIM);
  assign start_go  = (state_q == ST_IDLE) && start_req && !abort_req && rect_ok;
  assign start_bad = (state_q == ST_IDLE) && start_req && !abort_req && !rect_ok;

  // An ABORT strobe suppresses the fill write of its own cycle, so no pixel lands after it.
  assign fill_wr   = (state_q == ST_FILL) && !abort_req;
  assign fill_step = fill_wr && !cpu_we_i;
  assign last_px   = (x_q == x1) && (y_q == y1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start_go) state_nxt = ST_FILL;
      ST_FILL: begin
        if (abort_req)                 state_nxt = ST_IDLE;
        else if (fill_step && last_px) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == ST_FILL);
    vmem_we_o    = cpu_we_i || fill_wr;
    vmem_addr_o  = cpu_we_i ? cpu_addr_i  : {y_q, x_q};
    vmem_wdata_o = cpu_we_i ? cpu_wdata_i : color_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rect_q  <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (rect_wr)  rect_q  <= cfg_wdata_i;
      if (color_wr) color_q <= cfg_wdata_i[15:0];

      if (start_go) begin
        x_q <= x0;
        y_q <= y0;
      end else if (fill_step) begin
        if (x_q == x1) begin
          x_q <= x0;
          y_q <= y_q + 8'd1;
        end else begin
          x_q <= x_q + 8'd1;
        end
      end

      // Hardware set takes precedence over a simultaneous W1C.
      if (state_q == ST_DONE)             done_q <= 1'b1;
      else if (status_wr && cfg_wdata_i[1]) done_q <= 1'b0;

      if (start_bad)                      err_q <= 1'b1;
      else if (status_wr && cfg_wdata_i[2]) err_q <= 1'b0;
    end
  end

`ifdef VFILL_IRQ_EN
  logic irq_en_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        irq_en_q <= 1'b0;
    else if (ctrl_wr) irq_en_q <= cfg_wdata_i[2];
  end
  assign irq_en_rd = irq_en_q;
  assign irq_o     = done_q && irq_en_q;
`else
  assign irq_en_rd = 1'b0;
  assign irq_o     = 1'b0;
`endif

  always_comb begin
    rdata_nxt = '0;
    case (cfg_addr_i)
      2'd0: rdata_nxt = rect_q;
      2'd1: rdata_nxt = {16'h0000, color_q};
      2'd2: rdata_nxt = {29'd0, irq_en_rd, 2'b00};
      2'd3: rdata_nxt = {29'd0, err_q, done_q, busy_o};
      default: rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cfg_rdata_o <= '0;
    else       cfg_rdata_o <= rdata_nxt;
  end

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Directed self-checking bench for vmem_fill_ctrl; inputs change on negedge, vmem writes logged just before posedge.
module tb_vmem_fill_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic [31:0] cfg_rdata_o;
  logic        cpu_we_i = 1'b0;
  logic [15:0] cpu_addr_i = 16'h5050;
  logic [15:0] cpu_wdata_i = 16'h1234;
  logic        vmem_we_o;
  logic [15:0] vmem_addr_o;
  logic [15:0] vmem_wdata_o;
  logic        busy_o;
  logic        irq_o;

  vmem_fill_ctrl #(.XMAX(239), .YMAX(239)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
    .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .vmem_we_o(vmem_we_o), .vmem_addr_o(vmem_addr_o), .vmem_wdata_o(vmem_wdata_o),
    .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef VFILL_IRQ_EN
  localparam logic IRQ_FEAT = 1'b1;
`else
  localparam logic IRQ_FEAT = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];

  // Log every vmem write 1 time unit before the rising edge that commits it.
  always @(negedge clk_i) begin
    #4;
    if (vmem_we_o) begin
      wq_addr.push_back(vmem_addr_o);
      wq_data.push_back(vmem_wdata_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
    @(negedge clk_i);
    cfg_we_i = 1'b0; cfg_wdata_i = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk_i);
    cfg_we_i = 1'b0; cfg_addr_i = a;
    @(negedge clk_i);
    d = cfg_rdata_o;
  endtask

  // Call right after the START write returns; stall_cyc selects the FILL cycle that gets a CPU write.
  task automatic run_fill(input int stall_cyc, output int busy_cyc);
    int cyc = 1;
    while (busy_o && cyc < 400) begin
      cpu_we_i = (cyc == stall_cyc);
      @(negedge clk_i);
      cyc++;
    end
    cpu_we_i = 1'b0;
    busy_cyc = cyc - 1;
    check("fill_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          bc;
    int          nw;
    logic        saw_busy;
    logic [15:0] exp_a[7];

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_busy",  {31'd0, busy_o},    32'd0);
    check("rst_irq",   {31'd0, irq_o},     32'd0);
    check("rst_rdata", cfg_rdata_o,        32'd0);
    check("rst_vwe",   {31'd0, vmem_we_o}, 32'd0);
    rst_i = 1'b0;
    cfg_read(2'd3, rd); check("rst_status", rd, 32'd0);
    cfg_read(2'd0, rd); check("rst_rect",   rd, 32'd0);

    // Basic 3x2 fill
    cfg_write(2'd0, 32'h0102_0000);
    cfg_write(2'd1, 32'hABCD_F800);
    cfg_read(2'd1, rd); check("color_rb", rd, 32'h0000_F800);
    cfg_read(2'd0, rd); check("rect_rb",  rd, 32'h0102_0000);
    wq_addr.delete(); wq_data.delete();
    cfg_write(2'd2, 32'h1);
    run_fill(0, bc);
    check("basic_busy_cyc", bc, 6);
    check("basic_nwr", wq_addr.size(), 6);
    exp_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101, 16'h0102, 16'h0000};
    for (int i = 0; i < 6 && i < wq_addr.size(); i++) begin
      check($sformatf("basic_addr%0d", i), {16'd0, wq_addr[i]}, {16'd0, exp_a[i]});
      check($sformatf("basic_data%0d", i), {16'd0, wq_data[i]}, 32'h0000_F800);
    end
    cfg_read(2'd3, rd); check("basic_done", rd, 32'h2);
    cfg_write(2'd3, 32'h2);
    cfg_read(2'd3, rd); check("basic_w1c", rd, 32'h0);

    // CPU priority on 3rd FILL cycle
    wq_addr.delete(); wq_data.delete();
    cfg_write(2'd2, 32'h1);
    run_fill(3, bc);
    check("cpu_busy_cyc", bc, 7);
    check("cpu_nwr", wq_addr.size(), 7);
    exp_a = '{16'h0000, 16'h0001, 16'h5050, 16'h0002, 16'h0100, 16'h0101, 16'h0102};
    for (int i = 0; i < 7 && i < wq_addr.size(); i++)
      check($sformatf("cpu_addr%0d", i), {16'd0, wq_addr[i]}, {16'd0, exp_a[i]});
    if (wq_data.size() > 3) begin
      check("cpu_data2", {16'd0, wq_data[2]}, 32'h1234);
      check("cpu_data3", {16'd0, wq_data[3]}, 32'hF800);
    end
    cfg_read(2'd3, rd); check("cpu_done", rd, 32'h2);
    cfg_write(2'd3, 32'h2);

    // Bad rectangle (x0 > x1), then x1 beyond XMAX
    cfg_write(2'd0, 32'h0005_000A);
    wq_addr.delete(); wq_data.delete();
    cfg_write(2'd2, 32'h1);
    saw_busy = busy_o;
    repeat (5) begin @(negedge clk_i); saw_busy |= busy_o; end
    check("bad_busy", {31'd0, saw_busy}, 32'd0);
    check("bad_nwr", wq_addr.size(), 0);
    cfg_read(2'd3, rd); check("bad_err", rd, 32'h4);
    cfg_write(2'd3, 32'h4);
    cfg_read(2'd3, rd); check("bad_w1c", rd, 32'h0);
    cfg_write(2'd0, 32'h00F0_0000);
    cfg_write(2'd2, 32'h1);
    check("xmax_busy", {31'd0, busy_o}, 32'd0);
    cfg_read(2'd3, rd); check("xmax_err", rd, 32'h4);
    cfg_write(2'd3, 32'h4);

    // START together with ABORT from IDLE is a no-op
    cfg_write(2'd0, 32'h0102_0000);
    wq_addr.delete(); wq_data.delete();
    cfg_write(2'd2, 32'h3);
    repeat (3) @(negedge clk_i);
    check("sa_busy", {31'd0, busy_o}, 32'd0);
    check("sa_nwr", wq_addr.size(), 0);
    cfg_read(2'd3, rd); check("sa_status", rd, 32'h0);

    // Abort a full-screen fill after 100 writes
    cfg_write(2'd0, 32'hEFEF_0000);
    cfg_write(2'd1, 32'h0000_001F);
    wq_addr.delete(); wq_data.delete();
    cfg_write(2'd2, 32'h1);
    repeat (99) @(negedge clk_i);
    cfg_write(2'd2, 32'h2);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    repeat (5) @(negedge clk_i);
    check("abort_nwr", wq_addr.size(), 100);
    if (wq_addr.size() >= 100) begin
      check("abort_last_addr", {16'd0, wq_addr[99]}, 32'h0063);
      check("abort_last_data", {16'd0, wq_data[99]}, 32'h001F);
    end
    cfg_read(2'd3, rd); check("abort_status", rd, 32'h0);

    // Reset pulsed mid-fill
    cfg_write(2'd0, 32'h0909_0000);
    cfg_write(2'd1, 32'h0000_07E0);
    cfg_write(2'd2, 32'h1);
    repeat (3) @(negedge clk_i);
    check("mr_busy_pre", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("mr_busy",  {31'd0, busy_o}, 32'd0);
    check("mr_rdata", cfg_rdata_o,     32'd0);
    nw = wq_addr.size();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("mr_nwr", wq_addr.size(), nw);
    cfg_read(2'd3, rd); check("mr_status", rd, 32'h0);
    cfg_read(2'd1, rd); check("mr_color",  rd, 32'h0);

    // Single-pixel fill at the far corner with interrupt
    cfg_write(2'd2, 32'h4);
    cfg_read(2'd2, rd); check("irqen_rb", rd, {29'd0, IRQ_FEAT, 2'b00});
    cfg_write(2'd0, 32'hEFEF_EFEF);
    wq_addr.delete(); wq_data.delete();
    check("irq_pre", {31'd0, irq_o}, 32'd0);
    cfg_write(2'd2, 32'h5);
    run_fill(0, bc);
    check("px_busy_cyc", bc, 1);
    check("px_nwr", wq_addr.size(), 1);
    if (wq_addr.size() > 0) check("px_addr", {16'd0, wq_addr[0]}, 32'hEFEF);
    repeat (3) @(negedge clk_i);
    check("irq_set", {31'd0, irq_o}, {31'd0, IRQ_FEAT});
    cfg_write(2'd3, 32'h2);
    check("irq_clr", {31'd0, irq_o}, 32'd0);
    cfg_read(2'd3, rd); check("px_status", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vmem_fill_ctrl.md
VMEM_FILL_CTRL -- requirements
Module: vmem_fill_ctrl

Interface
REQ-001 Parameter XMAX, default 239, largest legal pixel column.
REQ-002 Parameter YMAX, default 239, largest legal pixel row.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 cfg_we_i  in  1  register write strobe from dbus decode.
REQ-006 cfg_addr_i  in  2  register select.
- 0 RECT
- 1 COLOR
- 2 CTRL
- 3 STATUS
REQ-007 cfg_wdata_i  in  32  register write data.
REQ-008 cfg_rdata_o  out  32  registered read data for cfg_addr_i.
REQ-009 cpu_we_i  in  1  CPU vmem write request.
REQ-010 cpu_addr_i  in  16  CPU vmem address {y,x}.
REQ-011 cpu_wdata_i  in  16  CPU RGB565 pixel.
REQ-012 vmem_we_o  out  1  vmem write enable.
REQ-013 vmem_addr_o  out  16  vmem write address {y[7:0],x[7:0]}.
REQ-014 vmem_wdata_o  out  16  vmem write data.
REQ-015 busy_o  out  1  high while state is FILL.
REQ-016 irq_o  out  1  fill-complete interrupt (see Configuration).

Function
REQ-017 RECT register fields: x0=[7:0], y0=[15:8], x1=[23:16], y1=[31:24].
REQ-018 COLOR register holds [15:0]; bits [31:16] read as 0.
REQ-019 CTRL register bits (write-only, self-clearing):
- bit0 START
- bit1 ABORT
- bit2 IRQ_EN, which is persistent and readable at CTRL[2].
REQ-020 STATUS register bits:
- bit0 busy
- bit1 done (sticky)
- bit2 err (sticky)
- bits [31:3] read as 0.
- Writing 1 to bit1 or bit2 clears that bit (W1C).
REQ-021 Reads: cfg_rdata_o updates every cycle to the register selected by cfg_addr_i (1-cycle latency).
REQ-022 FSM states are IDLE, FILL and DONE; reset state is IDLE.
REQ-023 START in IDLE with x0<=x1, y0<=y1, x1<=XMAX and y1<=YMAX: load x=x0, y=y0 and enter FILL next cycle.
REQ-024 START in IDLE with any of those conditions false: set err and remain in IDLE; no vmem write occurs.
REQ-025 START, RECT writes and COLOR writes while in FILL or DONE are ignored; err is not set.
REQ-026 FILL write cycle (cpu_we_i=0):
- vmem_we_o=1
- vmem_addr_o={y,x}
- vmem_wdata_o=COLOR
- counter advances.
REQ-027 Counter advance: when x==x1 then x<=x0 and y<=y+1; otherwise x<=x+1.
REQ-028 Leaving FILL: the write with x==x1 and y==y1 moves FILL->DONE; DONE sets done and returns to IDLE the following cycle.
REQ-029 CPU priority: when cpu_we_i=1, vmem_* pass cpu_* combinationally in any state, and the fill counter holds that cycle.
REQ-030 Outside FILL with cpu_we_i=0: vmem_we_o=0; vmem_addr_o and vmem_wdata_o are don't-care.
REQ-031 Total fill writes = (x1-x0+1)*(y1-y0+1); each pixel is written exactly once, row-major.
REQ-032 Fill cycles from FILL entry to DONE = pixel count plus number of CPU-stall cycles.
REQ-033 Single pixel (x0==x1, y0==y1): exactly one write, then DONE.
REQ-034 ABORT in FILL: enter IDLE next cycle; no further fill writes; done is not set.
REQ-035 ABORT outside FILL has no effect.
REQ-036 START and ABORT in the same write: ABORT wins; from IDLE this is a no-op.
REQ-037 Counters are 8-bit; no wrap occurs because x1<=XMAX<=255.

Reset
REQ-038 rst_i asserted, at any time including mid-FILL: the following take reset values immediately:
- state=IDLE
- RECT=0, COLOR=0, IRQ_EN=0
- done=0, err=0
- cfg_rdata_o=0
- busy_o=0, irq_o=0
REQ-039 During reset, vmem_we_o follows cpu_we_i only, with no fill writes; after deassertion the first action occurs on the next rising edge.

Configuration
REQ-040 With macro VFILL_IRQ_EN defined: irq_o = done & IRQ_EN, level-sensitive, cleared by the STATUS bit1 W1C write.
REQ-041 Without VFILL_IRQ_EN: irq_o is constant 0 and IRQ_EN reads as 0; the port remains present.

Verification
REQ-042 Basic fill:
- Stimulus: RECT={y1=1,x1=2,y0=0,x0=0}, COLOR=0xF800, START, no CPU traffic.
- Response: 6 writes at 0x0000, 0x0001, 0x0002, 0x0100, 0x0101, 0x0102, data 0xF800; done=1 one cycle after the last write.
REQ-043 CPU priority:
- Stimulus: same fill, cpu_we_i=1 (addr 0x5050, data 0x1234) on the 3rd FILL cycle.
- Response: that cycle writes 0x5050/0x1234; 0x0002 is written the next cycle; 7 write cycles total.
REQ-044 Bad rectangle:
- Stimulus: RECT x0=10, x1=5, then START.
- Response: err=1, busy_o never asserts, no vmem writes; W1C 0x4 to STATUS gives err=0.
REQ-045 Abort:
- Stimulus: full 240x240 fill, ABORT after 100 writes.
- Response: busy_o=0 next cycle, exactly 100 fill writes, done=0.
REQ-046 Mid-fill reset:
- Stimulus: rst_i pulsed during FILL.
- Response: busy_o=0, STATUS=0, COLOR=0 immediately; no writes after reset.
REQ-047 Interrupt:
- Stimulus: with VFILL_IRQ_EN and IRQ_EN=1, single-pixel fill at {239,239}.
- Response: 1 write to 0xEFEF, irq_o=1 until STATUS W1C 0x2; without the macro, irq_o stays 0.
